// File: rtl/cdc_fifo_stream_pkg.sv
// Shared types for the CDC FIFO stream reader.
//   occ_e : occupancy of the 2-entry output buffer (0, 1 or 2 words held).
package cdc_fifo_stream_pkg;

    typedef enum logic [1:0] {
        OCC_0 = 2'd0,
        OCC_1 = 2'd1,
        OCC_2 = 2'd2
    } occ_e;

endpackage

// File: rtl/cdc_fifo_stream_reader.sv
// Read-side adapter for the Gray-pointer CDC FIFO, entirely in the read clock domain.
// Turns the FIFO's empty/read-strobe interface (combinational head word) into a registered
// valid/ready stream through a 2-entry buffer, and counts accepted beats.
//
// Ports:
//   clk        : read-domain clock
//   rst        : synchronous active-high reset
//   enable     : when low, no new words are popped; buffered words still drain
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO head word, valid while fifo_empty is low
//   fifo_read  : pop strobe to the FIFO
//   m_valid    : stream valid (registered)
//   m_data     : stream data (registered)
//   m_ready    : stream ready
//   beat_count : accepted output beats, modulo 2^P_COUNT_WIDTH
module cdc_fifo_stream_reader
    import cdc_fifo_stream_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH  = 32,
    parameter int unsigned P_COUNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     fifo_empty,
    input  logic [P_DATA_WIDTH-1:0]  fifo_data,
    output logic                     fifo_read,
    output logic                     m_valid,
    output logic [P_DATA_WIDTH-1:0]  m_data,
    input  logic                     m_ready,
    output logic [P_COUNT_WIDTH-1:0] beat_count
);

    occ_e                     r_occ;
    logic [P_DATA_WIDTH-1:0]  r_entry0;
    logic [P_DATA_WIDTH-1:0]  r_entry1;
    logic [P_COUNT_WIDTH-1:0] r_beat_count;

    occ_e                     w_occ_d;
    logic [P_DATA_WIDTH-1:0]  w_entry0_d;
    logic [P_DATA_WIDTH-1:0]  w_entry1_d;
    logic [P_COUNT_WIDTH-1:0] w_beat_count_d;
    logic                     w_push;
    logic                     w_pop;

    always_comb begin
        // The read strobe looks only at buffer occupancy, never at m_ready, so there is no
        // combinational path from the stream sink back into the FIFO.
        w_push         = !rst && enable && !fifo_empty && (r_occ != OCC_2);
        w_pop          = (r_occ != OCC_0) && m_ready;
        w_occ_d        = r_occ;
        w_entry0_d     = r_entry0;
        w_entry1_d     = r_entry1;
        w_beat_count_d = w_pop ? r_beat_count + P_COUNT_WIDTH'(1) : r_beat_count;

        unique case (r_occ)
            OCC_0: begin
                if (w_push) begin
                    w_entry0_d = fifo_data;
                    w_occ_d    = OCC_1;
                end
            end
            OCC_1: begin
                if (w_push && w_pop) begin
                    w_entry0_d = fifo_data;
                end else if (w_push) begin
                    w_entry1_d = fifo_data;
                    w_occ_d    = OCC_2;
                end else if (w_pop) begin
                    w_occ_d    = OCC_0;
                end
            end
            OCC_2: begin
                if (w_pop) begin
                    w_entry0_d = r_entry1;
                    w_occ_d    = OCC_1;
                end
            end
            default: begin
                w_occ_d = OCC_0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ        <= OCC_0;
            r_entry0     <= '0;
            r_entry1     <= '0;
            r_beat_count <= '0;
        end else begin
            r_occ        <= w_occ_d;
            r_entry0     <= w_entry0_d;
            r_entry1     <= w_entry1_d;
            r_beat_count <= w_beat_count_d;
        end
    end

    assign fifo_read  = w_push;
    assign m_valid    = (r_occ != OCC_0);
    assign m_data     = r_entry0;
    assign beat_count = r_beat_count;

endmodule
